matmul_ctrl: RTL and testbench

Top-level sequencer for the matrix-multiply engine. It streams X, then Y, from an input FWFT FIFO into the X/Y BRAMs, pulses the engine start, and waits for engine completion. It then reads Z out of the Z BRAM into an output FIFO and loops back for the next matrix pair. It sits between the host-side FIFOs and the BRAM and engine datapath.

---
 rtl/matmul_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matmul_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ctrl.sv
// Purpose: top-level sequencer for the matrix-multiply engine; loads X then Y from the input FIFO, starts the engine, drains Z to the output FIFO.
// Latency: 2*N*N load cycles + 1 start + engine time + 1 edge detect + 2*N*N drain cycles per frame when nothing stalls.
// Backpressure: input pops only while in_empty is low; Z pushes hold in S_WR (same address, stable data) while out_full is high.
module matmul_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int MAT_DIM_WIDTH = 3,
   parameter int MAT_DIM_SIZE  = 2**MAT_DIM_WIDTH,
   parameter int ADDR_WIDTH    = 2*MAT_DIM_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_empty,
   input  logic [DATA_WIDTH-1:0] in_dout,
   output logic                  in_rd_en,
   output logic                  x_we,
   output logic [ADDR_WIDTH-1:0] x_addr,
   output logic [DATA_WIDTH-1:0] x_wdata,
   output logic                  y_we,
   output logic [ADDR_WIDTH-1:0] y_addr,
   output logic [DATA_WIDTH-1:0] y_wdata,
   output logic                  mm_strt,
   input  logic                  mm_done,
   output logic [ADDR_WIDTH-1:0] z_addr,
   input  logic [DATA_WIDTH-1:0] z_rdata,
   input  logic                  out_full,
   output logic                  out_wr_en,
   output logic [DATA_WIDTH-1:0] out_din,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [2:0] {
      S_LOAD_X = 3'd0,
      S_LOAD_Y = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_RD     = 3'd4,
      S_WR     = 3'd5
   } state_t;

   // Last element index of an N x N matrix, and a width-matched increment.
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(MAT_DIM_SIZE*MAT_DIM_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] K_ONE  = ADDR_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   k_q, k_d;
   logic                    mm_strt_q, mm_strt_d;
   logic                    frame_done_q, frame_done_d;
   logic                    mm_done_q;

   logic [MAT_DIM_WIDTH-1:0] row;
   logic [MAT_DIM_WIDTH-1:0] col;
   logic                     k_last;
   logic                     done_rise;
   logic                     in_load_x;
   logic                     in_load_y;

   assign row       = k_q[ADDR_WIDTH-1:MAT_DIM_WIDTH];
   assign col       = k_q[MAT_DIM_WIDTH-1:0];
   assign k_last    = (k_q == K_LAST);
   // Engine done may be sticky, so only a fresh 0->1 transition means "this frame is finished".
   assign done_rise = mm_done && !mm_done_q;
   assign in_load_x = (state_q == S_LOAD_X);
   assign in_load_y = (state_q == S_LOAD_Y);

   // FIFO pop doubles as the BRAM write strobe: FWFT head is written the cycle it is consumed.
   assign in_rd_en  = (in_load_x || in_load_y) && !in_empty;
   assign x_we      = in_load_x && !in_empty;
   assign x_addr    = k_q;
   assign x_wdata   = in_dout;
   assign y_we      = in_load_y && !in_empty;
   // Y arrives row-major; storing it as {col,row} makes each Y column a contiguous run for the engine.
   assign y_addr    = {col, row};
   assign y_wdata   = in_dout;

   // Z address is held across S_RD and S_WR, so a full output FIFO just keeps re-reading the same word.
   assign z_addr    = k_q;
   assign out_din   = z_rdata;
   assign out_wr_en = (state_q == S_WR) && !out_full;

   assign busy       = !(in_load_x && (k_q == '0));
   assign mm_strt    = mm_strt_q;
   assign frame_done = frame_done_q;

   // Next-state, counter and registered-pulse computation for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      mm_strt_d    = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         S_LOAD_X: begin
            if (!in_empty) begin
               if (k_last) begin
                  k_d     = '0;
                  state_d = S_LOAD_Y;
               end else begin
                  k_d = k_q + K_ONE;
               end
            end
         end
         S_LOAD_Y: begin
            if (!in_empty) begin
               if (k_last) begin
                  k_d       = '0;
                  state_d   = S_START;
                  mm_strt_d = 1'b1;
               end else begin
                  k_d = k_q + K_ONE;
               end
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (done_rise) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            if (!out_full) begin
               if (k_last) begin
                  k_d          = '0;
                  frame_done_d = 1'b1;
                  state_d      = S_LOAD_X;
               end else begin
                  k_d     = k_q + K_ONE;
                  state_d = S_RD;
               end
            end
         end
         default: begin
            state_d = S_LOAD_X;
            k_d     = '0;
         end
      endcase
   end

   // Sequencer state, element counter, pulse outputs and done-edge history; reset drops any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_LOAD_X;
         k_q          <= '0;
         mm_strt_q    <= 1'b0;
         frame_done_q <= 1'b0;
         mm_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         mm_strt_q    <= mm_strt_d;
         frame_done_q <= frame_done_d;
         mm_done_q    <= mm_done;
      end
   end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: random matrix frames through FIFO/BRAM/engine models, results compared with a matrix-product reference.
// Each frame is checked for load addressing, single start pulse, sticky-done handling, Z ordering, stalls and frame_done timing.
// Includes an asynchronous reset mid-drain followed by a clean frame.
module tb_matmul_ctrl;
   localparam int DW = 32;
   localparam int MW = 3;
   localparam int N  = 8;
   localparam int NN = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_empty;
   logic [DW-1:0] in_dout;
   logic          in_rd_en;
   logic          x_we;
   logic [AW-1:0] x_addr;
   logic [DW-1:0] x_wdata;
   logic          y_we;
   logic [AW-1:0] y_addr;
   logic [DW-1:0] y_wdata;
   logic          mm_strt;
   logic          mm_done;
   logic [AW-1:0] z_addr;
   logic [DW-1:0] z_rdata;
   logic          out_full;
   logic          out_wr_en;
   logic [DW-1:0] out_din;
   logic          busy;
   logic          frame_done;

   always #5 clk = ~clk;

   matmul_ctrl #(
      .DATA_WIDTH(DW),
      .MAT_DIM_WIDTH(MW),
      .MAT_DIM_SIZE(N),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
      .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
      .y_we(y_we), .y_addr(y_addr), .y_wdata(y_wdata),
      .mm_strt(mm_strt), .mm_done(mm_done),
      .z_addr(z_addr), .z_rdata(z_rdata),
      .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
      .busy(busy), .frame_done(frame_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Host FIFO, datapath BRAMs and reference results
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] xm[NN];
   logic [DW-1:0] ym[NN];
   logic [DW-1:0] zm[NN];
   logic [DW-1:0] exp_z[NN];

   // Frame progress as seen from outside: words consumed, results delivered
   int   w, ph, since, push_idx, nstrt;
   logic fd_exp, frame_over, aborted;

   // Engine model: sticky done, stale-high hold, then low, then rise with fresh Z
   int   eng_phase, eng_cnt;
   logic eng_done, eng_rose;

   // Stimulus knobs
   int   empty_mode, full_mode, stall_k, stall_left, rst_k;
   logic stall_used, tog;

   task automatic engine_compute();
      logic [DW-1:0] acc;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int i = 0; i < N; i++) acc = acc + xm[r*N+i] * ym[c*N+i];
            zm[r*N+c] = acc;
         end
   endtask

   task automatic reset_abort();
      in_empty = 1'b1;
      out_full = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", in_rd_en, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_x_we", x_we, 0);
      chk("rst_y_we", y_we, 0);
      chk("rst_strt", mm_strt, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_x_addr", x_addr, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      in_q.delete();
      w = 0; ph = 0; since = 0; push_idx = 0; fd_exp = 1'b0;
      eng_phase = 0; eng_done = 1'b0; eng_rose = 1'b0; mm_done = 1'b0;
      frame_over = 1'b1; aborted = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      logic [AW-1:0] za;
      tog = ~tog;
      case (empty_mode)
         0:       in_empty = 1'b0;
         1:       in_empty = tog;
         default: in_empty = ($urandom_range(0, 2) == 0);
      endcase
      if (in_q.size() == 0) in_empty = 1'b1;
      in_dout = (in_q.size() != 0) ? in_q[0] : $urandom;
      if (stall_left > 0)      out_full = 1'b1;
      else if (full_mode != 0) out_full = ($urandom_range(0, 3) == 0);
      else                     out_full = 1'b0;
      mm_done = eng_done;
      #4;
      za = z_addr;

      chk("busy", busy, !(ph == 0 && w == 0));
      chk("rd_en", in_rd_en, (ph == 0) && !in_empty);
      chk("mm_strt", mm_strt, (ph == 1) && (since == 0));
      chk("frame_done", frame_done, fd_exp);
      if (in_rd_en) begin
         if (w < NN) begin
            chk("x_we", x_we, 1);
            chk("x_idle_y", y_we, 0);
            chk("x_addr", x_addr, w);
            chk("x_wdata", x_wdata, in_dout);
         end else begin
            chk("y_we", y_we, 1);
            chk("y_idle_x", x_we, 0);
            chk("y_addr", y_addr, ((w-NN) % N) * N + (w-NN) / N);
            chk("y_wdata", y_wdata, in_dout);
         end
      end else if (x_we || y_we) begin
         chk("stray_we", {x_we, y_we}, 2'b00);
      end
      if (out_full) chk("wr_while_full", out_wr_en, 0);
      if (stall_left > 0) chk("stall_z_addr", z_addr, stall_k);
      if (out_wr_en) begin
         chk("push_phase", ph, 1);
         chk("push_after_done", eng_rose, 1);
         chk("z_addr", z_addr, push_idx);
         if (push_idx < NN) chk("out_din", out_din, exp_z[push_idx]);
      end

      if (rst_k >= 0 && out_wr_en && z_addr == rst_k) begin
         reset_abort();
         return;
      end

      if (ph == 1) since++;
      if (fd_exp) frame_over = 1'b1;
      fd_exp = 1'b0;
      if (x_we) xm[x_addr] = x_wdata;
      if (y_we) ym[y_addr] = y_wdata;
      if (in_rd_en && in_q.size() != 0) begin
         in_q.delete(0);
         w++;
         if (w == 2*NN) begin
            ph = 1;
            since = 0;
         end
      end
      if (mm_strt) begin
         nstrt++;
         eng_phase = 1;
         eng_cnt = $urandom_range(0, 4);
         eng_rose = 1'b0;
      end else begin
         case (eng_phase)
            1: if (eng_cnt == 0) begin
                  eng_done = 1'b0;
                  eng_phase = 2;
                  eng_cnt = $urandom_range(1, 5);
               end else eng_cnt--;
            2: if (eng_cnt == 0) begin
                  engine_compute();
                  eng_done = 1'b1;
                  eng_rose = 1'b1;
                  eng_phase = 0;
               end else eng_cnt--;
            default: ;
         endcase
      end
      if (out_wr_en) begin
         push_idx++;
         if (push_idx == NN) begin
            fd_exp = 1'b1;
            ph = 0;
            w = 0;
         end
      end
      if (stall_left > 0) stall_left--;
      if (stall_k >= 0 && !stall_used && ph == 1 && z_addr == stall_k && !out_wr_en) begin
         stall_left = 5;
         stall_used = 1'b1;
      end

      @(posedge clk);
      #1;
      z_rdata = zm[za];
   endtask

   task automatic run_frame(input int xmode, input int emode, input int fmode, input int sk, input int rk);
      logic [DW-1:0] xs[NN];
      logic [DW-1:0] ys[NN];
      logic [DW-1:0] acc;
      for (int i = 0; i < NN; i++) begin
         if (xmode == 1) begin
            xs[i] = (i / N == i % N) ? 32'd1 : 32'd0;
            ys[i] = i;
         end else begin
            xs[i] = $urandom;
            ys[i] = $urandom;
         end
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int i = 0; i < N; i++) acc = acc + xs[r*N+i] * ys[i*N+c];
            exp_z[r*N+c] = acc;
         end
      for (int i = 0; i < NN; i++) in_q.push_back(xs[i]);
      for (int i = 0; i < NN; i++) in_q.push_back(ys[i]);
      empty_mode = emode; full_mode = fmode; stall_k = sk; rst_k = rk;
      stall_left = 0; stall_used = 1'b0;
      w = 0; ph = 0; since = 0; push_idx = 0; nstrt = 0;
      frame_over = 1'b0; aborted = 1'b0;
      for (int c = 0; c < 3000 && !frame_over; c++) cycle();
      chk("frame_timeout", frame_over, 1);
      if (!aborted) begin
         chk("push_count", push_idx, NN);
         chk("strt_count", nstrt, 1);
         if (sk >= 0) chk("stall_seen", stall_used, 1);
      end
   endtask

   initial begin
      rst = 1'b1; in_empty = 1'b1; in_dout = '0; mm_done = 1'b0; out_full = 1'b0; z_rdata = '0;
      tog = 1'b0; eng_done = 1'b0; eng_rose = 1'b0; eng_phase = 0; eng_cnt = 0;
      w = 0; ph = 0; since = 0; push_idx = 0; nstrt = 0; fd_exp = 1'b0;
      empty_mode = 0; full_mode = 0; stall_k = -1; stall_left = 0; rst_k = -1; stall_used = 1'b0;
      frame_over = 1'b0; aborted = 1'b0;
      for (int i = 0; i < NN; i++) begin
         xm[i] = '0; ym[i] = '0; zm[i] = '0;
      end
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_strt", mm_strt, 0);
      chk("reset_fd", frame_done, 0);
      chk("reset_rd_en", in_rd_en, 0);
      chk("reset_wr_en", out_wr_en, 0);
      chk("reset_x_we", x_we, 0);
      chk("reset_y_we", y_we, 0);
      chk("reset_x_addr", x_addr, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_frame(1, 0, 0, -1, -1);   // identity X, ramp Y: output 0..63
      run_frame(0, 1, 0, -1, -1);   // toggling empty, sticky done from previous frame
      run_frame(0, 2, 1, -1, -1);   // random empty and full
      run_frame(0, 0, 0, 10, -1);   // five-cycle full stall at word 10
      run_frame(0, 2, 0, -1, 30);   // async reset in S_WR at word 30
      run_frame(0, 1, 1, -1, -1);   // clean frame after reset
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
